// File: rtl/wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
//   Round-robin arbiter that lets NUM_MASTERS Wishbone initiators share a
//   single Wishbone slave port. One transfer is granted at a time. Every
//   transfer ends by ack, by the owner dropping cyc (abort) or by a timeout
//   error. After the transfer, priority moves to the master above the
//   previous owner.
//
// Handshake: a master requests with cyc&stb. The request stays pending until
//   the master sees its own ack or err bit high at a clock edge. The slave
//   completes a transfer by raising s_ack_i for one cycle while the arbiter
//   is BUSY.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   m_cyc_i/m_stb_i/m_we_i per-master cycle, strobe, write enable
//   m_adr_i/m_dat_i/m_sel_i packed per-master address, write data, byte sel
//   m_ack_o/m_err_o       per-master acknowledge / timeout error
//   m_dat_o               read data broadcast to all masters
//   s_*_o                 slave-side request (follows the granted master)
//   s_ack_i/s_dat_i       slave-side response
//   grant_o               index of the current or last owner (debug)
//   busy_o                high while a transfer is owned (FSM state)
// ---------------------------------------------------------------------------
module wb_rr_arbiter #(
    parameter int NUM_MASTERS = 5,
    parameter int ADR_W       = 32,
    parameter int DAT_W       = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_MASTERS-1:0]         m_cyc_i,
    input  logic [NUM_MASTERS-1:0]         m_stb_i,
    input  logic [NUM_MASTERS-1:0]         m_we_i,
    input  logic [NUM_MASTERS*ADR_W-1:0]   m_adr_i,
    input  logic [NUM_MASTERS*DAT_W-1:0]   m_dat_i,
    input  logic [NUM_MASTERS*DAT_W/8-1:0] m_sel_i,
    output logic [NUM_MASTERS-1:0]         m_ack_o,
    output logic [NUM_MASTERS-1:0]         m_err_o,
    output logic [DAT_W-1:0]               m_dat_o,
    output logic                           s_cyc_o,
    output logic                           s_stb_o,
    output logic                           s_we_o,
    output logic [ADR_W-1:0]               s_adr_o,
    output logic [DAT_W-1:0]               s_dat_o,
    output logic [DAT_W/8-1:0]             s_sel_o,
    input  logic                           s_ack_i,
    input  logic [DAT_W-1:0]               s_dat_i,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_o,
    output logic                           busy_o
);

    localparam int SEL_W = DAT_W / 8;
    localparam int GW    = $clog2(NUM_MASTERS);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [GW-1:0]          prio_q, prio_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [NUM_MASTERS-1:0] req;
    logic [GW-1:0]          winner;
    logic [GW-1:0]          g_next;
    logic                   found;
    int                     idx;
    logic                   active;
    logic                   g_cyc;
    logic                   g_stb;
    logic                   tmo_cycle;
    logic                   tmo_fire;

    assign req = m_cyc_i & m_stb_i;

    // Rotating search starting at prio; first requester found wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            idx = int'(prio_q) + i;
            if (idx >= NUM_MASTERS) begin
                idx = idx - NUM_MASTERS;
            end
            if (!found && req[GW'(idx)]) begin
                found  = 1'b1;
                winner = GW'(idx);
            end
        end
    end

    assign g_next = (grant_q == GW'(NUM_MASTERS - 1)) ? '0 : grant_q + GW'(1);

    // Outputs are suppressed during the reset cycle itself so that a reset
    // landing on a live transfer never lets an ack or err through.
    assign active = (state_q == BUSY) && !rst_i;
    assign g_cyc  = m_cyc_i[grant_q];
    assign g_stb  = m_stb_i[grant_q];

    // cnt_q holds the number of completed BUSY cycles, so the current BUSY
    // cycle is number cnt_q+1; the timeout fires on BUSY cycle TIMEOUT.
    // The register therefore tops out at TIMEOUT-1 and can never wrap.
    assign tmo_cycle = (TIMEOUT > 0) && active && (int'(cnt_q) + 1 == TIMEOUT);
    // Ack beats timeout; an owner that already dropped cyc is an abort.
    assign tmo_fire  = tmo_cycle && !s_ack_i && g_cyc;

    assign s_cyc_o = active && g_cyc && !tmo_fire;
    assign s_stb_o = active && g_stb && !tmo_fire;
    assign s_we_o  = m_we_i[grant_q];
    assign s_adr_o = m_adr_i[grant_q*ADR_W +: ADR_W];
    assign s_dat_o = m_dat_i[grant_q*DAT_W +: DAT_W];
    assign s_sel_o = m_sel_i[grant_q*SEL_W +: SEL_W];
    assign m_dat_o = s_dat_i;
    assign grant_o = grant_q;
    assign busy_o  = active;

    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            m_ack_o[k] = active && s_ack_i && (grant_q == GW'(k));
            m_err_o[k] = tmo_fire && (grant_q == GW'(k));
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BUSY;
                    grant_d = winner;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                // Ack, abort and timeout all end ownership the same way,
                // which also forces the IDLE gap before the next grant.
                if (s_ack_i || !g_cyc || tmo_fire) begin
                    state_d = IDLE;
                    prio_d  = g_next;
                    cnt_d   = '0;
                end else if (TIMEOUT > 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            prio_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_rr_arbiter
//   Directed bench for wb_rr_arbiter (5 masters, TIMEOUT=4). Stimulus pushes
//   the expected response of each transfer, {grant, ack vector, err vector},
//   into exp_q; a monitor pops and compares whenever any ack or err appears.
//   Masters drop their request after seeing their own ack/err unless marked
//   persistent. The slave model acks after slave_wait extra BUSY cycles.
// ---------------------------------------------------------------------------
module tb_wb_rr_arbiter;

    localparam int N   = 5;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;
    localparam int W   = 13;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [N-1:0]      m_cyc_i = '0;
    logic [N-1:0]      m_stb_i = '0;
    logic [N-1:0]      m_we_i = '0;
    logic [N*AW-1:0]   m_adr_i = '0;
    logic [N*DW-1:0]   m_dat_i = '0;
    logic [N*DW/8-1:0] m_sel_i = '0;
    logic [N-1:0]      m_ack_o;
    logic [N-1:0]      m_err_o;
    logic [DW-1:0]     m_dat_o;
    logic              s_cyc_o;
    logic              s_stb_o;
    logic              s_we_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic [DW/8-1:0]   s_sel_o;
    logic              s_ack_i = 1'b0;
    logic [DW-1:0]     s_dat_i = '0;
    logic [2:0]        grant_o;
    logic              busy_o;

    wb_rr_arbiter #(
        .NUM_MASTERS(N), .ADR_W(AW), .DAT_W(DW), .TIMEOUT(TMO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           passes = 0;
    logic [N-1:0] persist = '0;
    logic [N-1:0] done_vec = '0;
    logic         slave_en = 1'b0;
    int           slave_wait = 0;
    int           wcnt = 0;
    int           cyc_n = 0;
    int           busy_run = 0;
    logic         gap_pending = 1'b0;
    logic         period_chk = 1'b0;
    int           exp_period = 0;
    int           last_ack[N];

    function automatic logic [AW-1:0] adr_of(input int k);
        return 32'h1000_0000 + 32'(k) * 32'h10;
    endfunction
    function automatic logic [DW-1:0] dat_of(input int k);
        return 32'hD000_0000 | 32'(k);
    endfunction

    function automatic logic [W-1:0] mk(input int g, input logic is_ack);
        logic [N-1:0] one;
        one = N'(1) << g;
        return {3'(g), (is_ack ? one : N'(0)), (is_ack ? N'(0) : one)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- driver tasks ----------------
    task automatic req(input int k);
        m_cyc_i[k] = 1'b1;
        m_stb_i[k] = 1'b1;
    endtask

    task automatic drop(input int k);
        m_cyc_i[k] = 1'b0;
        m_stb_i[k] = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i   = 1'b1;
        m_cyc_i = '0;
        m_stb_i = '0;
        step();
        step();
        rst_i = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // ---------------- slave model ----------------
    always @(posedge clk_i) begin
        #2;
        s_dat_i = $urandom;
        if (slave_en && busy_o) begin
            if (wcnt == slave_wait) begin
                s_ack_i = 1'b1;
                wcnt    = 0;
            end else begin
                s_ack_i = 1'b0;
                wcnt++;
            end
        end else begin
            s_ack_i = 1'b0;
            wcnt    = 0;
        end
    end

    // ---------------- master model ----------------
    always @(posedge clk_i) begin
        #1;
        for (int k = 0; k < N; k++) begin
            if (done_vec[k] && !persist[k]) drop(k);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk_i) begin
        logic [W-1:0] e;
        int eg;
        cyc_n++;
        done_vec = m_ack_o | m_err_o;
        if (busy_o) busy_run++;
        else busy_run = 0;
        if (gap_pending) begin
            check("idle_gap", 32'(busy_o), 0);
            gap_pending = 1'b0;
        end
        if (m_ack_o != '0 || m_err_o != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", {16'(m_ack_o), 16'(m_err_o)}, 0);
            end else begin
                e  = exp_q.pop_front();
                eg = int'(e[W-1:W-3]);
                check("resp{grant,ack,err}", 32'({grant_o, m_ack_o, m_err_o}), 32'(e));
                check("s_adr_mux", s_adr_o, adr_of(eg));
                check("s_dat_mux", s_dat_o, dat_of(eg));
                check("s_sel_we_mux", {s_sel_o, 3'b000, s_we_o}, {4'(eg + 1), 3'b000, 1'(eg % 2)});
            end
            check("m_dat_bcast", m_dat_o, s_dat_i);
            if (m_err_o != '0) begin
                check("tmo_cyc_stb_low", {s_cyc_o, s_stb_o}, 0);
                check("tmo_busy_cycle", busy_run, TMO);
            end
            if (period_chk) begin
                for (int k = 0; k < N; k++) begin
                    if (m_ack_o[k]) begin
                        if (last_ack[k] >= 0) check("ack_period", cyc_n - last_ack[k], exp_period);
                        last_ack[k] = cyc_n;
                    end
                end
            end
            gap_pending = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int k = 0; k < N; k++) begin
            m_adr_i[k*AW +: AW] = adr_of(k);
            m_dat_i[k*DW +: DW] = dat_of(k);
            m_sel_i[k*4 +: 4]   = 4'(k + 1);
            m_we_i[k]           = k[0];
            last_ack[k]         = -1;
        end

        // Reset state
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check("rst_busy_cyc_stb", {busy_o, s_cyc_o, s_stb_o}, 0);
        check("rst_ack_err", {m_ack_o, m_err_o}, 0);
        check("rst_grant", grant_o, 0);
        step();
        rst_i = 1'b0;

        // Masters 0 and 3 together, slave acks on the third BUSY cycle
        slave_en = 1'b1; slave_wait = 2;
        exp_q.push_back(mk(0, 1'b1));
        exp_q.push_back(mk(3, 1'b1));
        req(0); req(3);
        drain("drain_pair", 40);
        step();

        // All masters continuous, zero-wait slave: rotation 0..4 twice
        do_reset();
        slave_wait = 0; persist = '1; period_chk = 1'b1; exp_period = 10;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < N; k++) exp_q.push_back(mk(k, 1'b1));
        for (int k = 0; k < N; k++) req(k);
        drain("drain_rotate", 60);
        m_cyc_i = '0; m_stb_i = '0; persist = '0; period_chk = 1'b0;
        step();

        // Timeout: prio 0, masters 2 and 3 request, slave silent
        slave_en = 1'b0;
        exp_q.push_back(mk(2, 1'b0));
        exp_q.push_back(mk(3, 1'b0));
        req(2); req(3);
        drain("drain_timeout", 40);
        step();

        // Abort: prio 4, master 1 alone, drops cyc on its 2nd BUSY cycle
        req(1);
        step();
        check("abort_granted", {busy_o, 4'(grant_o)}, {1'b1, 4'd1});
        step();
        drop(1);
        check("abort_no_resp", {m_ack_o, m_err_o}, 0);
        step();
        check("abort_idle", 32'(busy_o), 0);
        slave_en = 1'b1; slave_wait = 0;
        exp_q.push_back(mk(2, 1'b1));
        exp_q.push_back(mk(0, 1'b1));
        req(0); req(2);
        drain("drain_after_abort", 40);
        step();

        // Reset mid-transaction: prio 1, master 3 granted, then reset
        slave_en = 1'b0;
        req(3);
        step();
        check("mid_busy_grant", {busy_o, 4'(grant_o)}, {1'b1, 4'd3});
        rst_i = 1'b1;
        step();
        check("mid_rst_outputs", {busy_o, s_cyc_o, s_stb_o, 3'(grant_o)}, 0);
        check("mid_rst_ack_err", {m_ack_o, m_err_o}, 0);
        rst_i = 1'b0;
        drop(3);
        slave_en = 1'b1; slave_wait = 1;
        exp_q.push_back(mk(0, 1'b1));
        exp_q.push_back(mk(4, 1'b1));
        req(0); req(4);
        drain("drain_after_rst", 40);
        step();

        // Ack on the timeout cycle (4th BUSY cycle) wins over err
        slave_wait = 3;
        exp_q.push_back(mk(1, 1'b1));
        req(1);
        drain("drain_ack_vs_tmo", 40);
        step();

        // Single persistent requester granted every second cycle
        slave_wait = 0; persist[2] = 1'b1; period_chk = 1'b1; exp_period = 2;
        for (int k = 0; k < N; k++) last_ack[k] = -1;
        for (int r = 0; r < 3; r++) exp_q.push_back(mk(2, 1'b1));
        req(2);
        drain("drain_single", 30);
        drop(2); persist = '0; period_chk = 1'b0;
        step();
        step();
        check("final_idle", {busy_o, s_cyc_o}, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 5, number of Wishbone initiators (four FazyRV cores plus OLED DMA); legal range 2..16.
REQ-002 SHALL have parameter ADR_W, default 32, address width.
REQ-003 SHALL have parameter DAT_W, default 32, data width; byte-select width is DAT_W/8.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum BUSY cycles without ack; 0 disables the timeout.
REQ-005 SHALL have port clk_i, input, 1, the single clock.
REQ-006 SHALL have port rst_i, input, 1, reset; one clock, reset is synchronous and active-high.
REQ-007 SHALL have input ports m_cyc_i, m_stb_i and m_we_i, each NUM_MASTERS wide, per-master cycle, strobe and write-enable.
REQ-008 SHALL have input port m_adr_i, NUM_MASTERS*ADR_W wide, packed per-master addresses; master k occupies slice k.
REQ-009 SHALL have input ports m_dat_i (NUM_MASTERS*DAT_W) and m_sel_i (NUM_MASTERS*DAT_W/8), packed per-master write data and byte selects.
REQ-010 SHALL have output ports m_ack_o and m_err_o, each NUM_MASTERS wide, per-master acknowledge and error.
REQ-011 SHALL have output port m_dat_o, DAT_W wide, read data broadcast to all masters.
REQ-012 SHALL have output ports s_cyc_o, s_stb_o and s_we_o (1 each), s_adr_o (ADR_W), s_dat_o (DAT_W) and s_sel_o (DAT_W/8), the slave-side request.
REQ-013 SHALL have input ports s_ack_i (1) and s_dat_i (DAT_W), the slave-side response.
REQ-014 SHALL have output port grant_o, $clog2(NUM_MASTERS) wide, index of the current or last owner, for debug.
REQ-015 SHALL have output port busy_o, 1, high while in BUSY.

Function
REQ-016 SHALL implement an FSM with states IDLE and BUSY.
REQ-017 A request from master k SHALL be m_cyc_i[k] & m_stb_i[k].
REQ-018 In IDLE, if any request is present, the arbiter SHALL register the winner at the next edge and enter BUSY.
- Winner: the first requester found searching upward from index prio, wrapping modulo NUM_MASTERS.
- Grant latency is one cycle.
REQ-019 In IDLE, s_cyc_o and s_stb_o SHALL be 0.
REQ-020 In BUSY, the slave-side outputs SHALL combinationally follow the granted master:
- s_cyc_o = m_cyc_i[g] and s_stb_o = m_stb_i[g];
- s_we_o, s_adr_o, s_dat_o and s_sel_o follow the granted master's slices.
REQ-021 m_ack_o[g] SHALL equal s_ack_i while in BUSY; all other m_ack_o bits SHALL be 0.
REQ-022 m_dat_o SHALL equal s_dat_i at all times.
REQ-023 On s_ack_i in BUSY, the FSM SHALL:
- return to IDLE at the next edge;
- set prio to (g+1) mod NUM_MASTERS;
- leave at least one IDLE cycle between grants.
REQ-024 If m_cyc_i[g] drops in BUSY without an ack (abort), the FSM SHALL return to IDLE and set prio to g+1, with no ack or err issued.
REQ-025 With TIMEOUT>0, a counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack.
- When the counter equals TIMEOUT, m_err_o[g] SHALL pulse for exactly one cycle.
- In that cycle s_cyc_o and s_stb_o SHALL be forced to 0.
- The FSM then returns to IDLE and prio advances.
REQ-026 The timeout counter width SHALL be $clog2(TIMEOUT+1) and SHALL never wrap.
REQ-027 If s_ack_i and the timeout occur in the same cycle, the ack SHALL win and no err is issued.
REQ-028 Requests from non-granted masters arriving in BUSY SHALL be held off (no ack) until arbitrated later.
REQ-029 A master holding cyc across back-to-back strobes SHALL lose ownership after each ack.
- This is intentional: it bounds latency for the other masters.
REQ-030 With a single persistent requester, the arbiter SHALL grant it every second cycle.

Reset
REQ-031 While rst_i is high at a clock edge, the block SHALL enter IDLE and clear prio, grant_o and the timeout counter to 0; busy_o, s_cyc_o, s_stb_o, m_ack_o and m_err_o SHALL be 0.
REQ-032 Reset asserted mid-transaction SHALL abort it: s_cyc_o SHALL be 0 the cycle after the reset edge, and no ack or err reaches any master.

Verification
REQ-033 Requests from masters 0 and 3 together after reset, slave acks 2 cycles after stb -> master 0 granted first and acked; IDLE gap; then master 3 granted and acked; grant_o sequence 0 then 3.
REQ-034 All 5 masters requesting continuously with a zero-wait slave -> grants rotate 0,1,2,3,4,0; each master receives exactly one ack per 10 cycles.
REQ-035 TIMEOUT=4, master 2 granted and slave never acks -> m_err_o[2] high for one cycle on the 4th BUSY cycle with s_cyc_o=0 that cycle; next grant goes to master 3 if requesting.
REQ-036 Master 1 granted, then drops cyc after 1 cycle -> return to IDLE, no ack or err, prio=2.
REQ-037 rst_i pulsed during a BUSY transaction -> outputs are at reset values next cycle; after release, master 0 wins a simultaneous request from masters 0 and 4.
REQ-038 s_ack_i coinciding with the timeout cycle -> ack delivered, m_err_o stays 0.
